base_acredit_snk: RTL and testbench
===================================

Name: base_acredit_snk

Overview:
- Receive end of a credit-flow link. Sits directly downstream of the credit source stage.
- Accepts valid-only beats into a buffer of exactly `credits` entries. No backpressure toward the sender.
- Presents buffered beats to the consumer over a valid/ready interface.
- Returns one credit pulse per beat the consumer takes, which restores one upstream credit.

Parameters:
- credits, 1, buffer depth; must equal the upstream source's credit count; legal range ≥1, any value (not restricted to a power of two).
- width, 1, data width in bits.
- log_credits, $clog2(credits+1), width of the occupancy counter.
- log_depth, ($clog2(credits)>0 ? $clog2(credits) : 1), width of the read/write pointers.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_v  input  1  incoming beat valid; no ready exists, the sender's credits guarantee space.
- i_d  input  width  incoming beat data.
- o_c  output  1  credit return, one-cycle pulse per freed entry; drives the source's credit input.
- o_r  input  1  consumer ready.
- o_v  output  1  beat available to consumer.
- o_d  output  width  head-of-buffer data; valid when o_v=1.
- o_err  output  1  sticky overflow flag.

Behaviour:
- Reset: count=0, rptr=0, wptr=0, o_v=0, o_c=0, o_err=0. Storage contents are don't-care.
- Enqueue (enq) = i_v & (~full | deq).
  - Writes i_d into mem[wptr] at the clock edge.
  - wptr advances by 1 and wraps from credits-1 to 0.
- Dequeue (deq) = o_v & o_r. rptr advances by 1 with the same wrap rule.
- o_v = (count != 0). o_d = mem[rptr], read combinationally from registered storage.
- No bypass path: a beat written in cycle N is visible on o_v/o_d in cycle N+1 at the earliest.
- Occupancy update:
  - enq only: count+1.
  - deq only: count-1.
  - enq and deq together: count unchanged. Storage returns the old head on o_d while the new beat is written to a different slot, or to the same slot when full.
- full = (count == credits).
- Overflow: i_v & full & ~deq.
  - The beat is dropped.
  - Pointers and count are unchanged.
  - o_err is set and stays set until reset.
  - A correct sender never causes this.
- Credit return: o_c is registered. o_c in cycle N+1 equals deq in cycle N.
  - Exactly one pulse per dequeued beat.
  - Back-to-back dequeues give back-to-back pulses.
  - No pulse is generated for an overflowed (dropped) beat.
- Credit conservation: after reset, (beats dequeued) equals (o_c pulses), with at most one pulse in flight.
- Empty with o_r=1: no deq, no o_c.
- Reset mid-operation:
  - The buffer is flushed and any pending o_c is cancelled.
  - Both ends of the link must reset together, so the source reloads its full credit count.
- credits=1: single entry. Pointers stay 0 and full equals o_v.

Decomposition:
- No shared package needed. The pointer-wrap increment function ((p==credits-1)?0:p+1) may live in the common base utility package if one exists.
- One sub-module is natural: base_acredit_snk_mem, a credits×width register file with one synchronous write port and one combinational read port.
- Counters, pointers, overflow logic and the credit register stay in the top module.

Test Plan:
- Reset, then i_v=0 for 5 cycles -> o_v=0, o_c=0, o_err=0 throughout.
- credits=4, o_r=1, single beat i_d=0xA5 in cycle 0 -> o_v=1 with o_d=0xA5 in cycle 1; o_c=1 in cycle 2 only.
- credits=4, o_r=0, beats 1,2,3,4 on consecutive cycles, then o_r=1 -> count reaches 4; o_d gives 1,2,3,4 in order on 4 consecutive cycles; 4 back-to-back o_c pulses each lag its dequeue by one cycle; o_err=0.
- credits=3, full (3 beats), then i_v with o_r=0 -> beat dropped, o_err=1 and stays 1; the next dequeues still return the 3 original beats.
- credits=3, full, same cycle i_v=1 (data 9) and o_r=1 -> no overflow, o_err=0, count stays 3; after draining, 9 is the last beat out; pointers wrap correctly past index 2.
- Mid-stream reset with 2 beats buffered and a deq in the preceding cycle -> next cycle o_v=0 and o_c=0 (pending pulse cancelled); a subsequent beat flows normally.

Source files
------------

// File: rtl/base_acredit_snk_pkg.sv
// Shared helpers for the credit-flow receive buffer.
package base_acredit_snk_pkg;

  // Modulo-n pointer increment; n need not be a power of two.
  function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned n);
    return (p == 32'(n - 1)) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/base_acredit_snk_mem.sv
// Register-file storage: one synchronous write port, one combinational read port.
module base_acredit_snk_mem #(
  parameter int depth     = 1,
  parameter int width     = 1,
  parameter int log_depth = 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [log_depth-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [log_depth-1:0] raddr,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem [depth];

  // Contents are deliberately not reset; occupancy tracking makes them don't-care.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/base_acredit_snk.sv
// Credit-flow sink: buffers valid-only beats, hands them to a valid/ready
// consumer and returns one registered credit pulse per beat taken.
module base_acredit_snk
  import base_acredit_snk_pkg::*;
#(
  parameter int credits     = 1,
  parameter int width       = 1,
  parameter int log_credits = $clog2(credits + 1),
  parameter int log_depth   = ($clog2(credits) > 0 ? $clog2(credits) : 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic [width-1:0] i_d,
  output logic             o_c,
  input  logic             o_r,
  output logic             o_v,
  output logic [width-1:0] o_d,
  output logic             o_err
);

  logic [log_credits-1:0] count;
  logic [log_depth-1:0]   rptr;
  logic [log_depth-1:0]   wptr;
  logic                   full;
  logic                   enq;
  logic                   deq;

  assign o_v  = (count != '0);
  assign full = (count == log_credits'(credits));
  assign deq  = o_v & o_r;
  // A simultaneous dequeue frees the slot, so a full buffer can still accept.
  assign enq  = i_v & (~full | deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      o_c   <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_c <= deq;
      if (enq) wptr <= log_depth'(ptr_inc(32'(wptr), credits));
      if (deq) rptr <= log_depth'(ptr_inc(32'(rptr), credits));
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
      if (i_v && full && !deq) o_err <= 1'b1;
    end
  end

  base_acredit_snk_mem #(
    .depth    (credits),
    .width    (width),
    .log_depth(log_depth)
  ) u_mem (
    .clk  (clk),
    .we   (enq),
    .waddr(wptr),
    .wdata(i_d),
    .raddr(rptr),
    .rdata(o_d)
  );

endmodule

// File: tb/tb_base_acredit_snk.sv
// Bench for base_acredit_snk: two instances (credits 4 and 3), directed steps
// plus a per-instance scoreboard of expected beats and credit pulses.
module tb_base_acredit_snk;

  logic       clk = 1'b0;
  logic [1:0] reset;
  logic [1:0] i_v;
  logic [1:0] o_r;
  logic [7:0] i_d [2];
  logic [1:0] o_c;
  logic [1:0] o_v;
  logic [1:0] o_err;
  logic [7:0] o_d [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int C = (g == 0) ? 4 : 3;

    base_acredit_snk #(.credits(C), .width(8)) dut (
      .clk  (clk),
      .reset(reset[g]),
      .i_v  (i_v[g]),
      .i_d  (i_d[g]),
      .o_c  (o_c[g]),
      .o_r  (o_r[g]),
      .o_v  (o_v[g]),
      .o_d  (o_d[g]),
      .o_err(o_err[g])
    );

    logic [7:0] q [$];
    bit pend  = 1'b0;
    bit eerr  = 1'b0;
    bit armed = 1'b0;
    bit mdeq;
    int ndeq  = 0;
    int nc    = 0;

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // sees exactly what the DUT will act on.
    always @(negedge clk) begin
      mdeq = (q.size() != 0) && o_r[g];
      if (armed) begin
        chk("o_c", g, 32'(o_c[g]), 32'(pend));
        chk("o_v", g, 32'(o_v[g]), 32'(q.size() != 0));
        chk("o_err", g, 32'(o_err[g]), 32'(eerr));
        if (o_c[g]) nc++;
        if (mdeq) chk("o_d", g, 32'(o_d[g]), 32'(q.pop_front()));
      end else if (mdeq) begin
        void'(q.pop_front());
      end
      if (reset[g]) begin
        q.delete();
        pend  = 1'b0;
        eerr  = 1'b0;
        armed = 1'b1;
      end else begin
        if (mdeq) ndeq++;
        if (i_v[g]) begin
          if (q.size() < C) q.push_back(i_d[g]);
          else eerr = 1'b1;
        end
        pend = mdeq;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int g, input logic [7:0] d);
    i_v[g] = 1'b1;
    i_d[g] = d;
    tick();
    i_v[g] = 1'b0;
  endtask

  initial begin
    reset = 2'b11;
    i_v   = 2'b00;
    o_r   = 2'b00;
    i_d[0] = 8'h00;
    i_d[1] = 8'h00;
    tick(2);
    reset = 2'b00;

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      chk("idle_o_v", 0, 32'(o_v[0]), 32'd0);
      chk("idle_o_c", 0, 32'(o_c[0]), 32'd0);
      chk("idle_o_err", 1, 32'(o_err[1]), 32'd0);
      tick();
    end

    // Single beat with consumer ready: visible next cycle, credit the one after.
    o_r[0] = 1'b1;
    beat(0, 8'hA5);
    chk("single_o_v", 0, 32'(o_v[0]), 32'd1);
    chk("single_o_d", 0, 32'(o_d[0]), 32'hA5);
    chk("single_o_c_early", 0, 32'(o_c[0]), 32'd0);
    tick();
    chk("single_o_c", 0, 32'(o_c[0]), 32'd1);
    tick();
    chk("single_o_c_once", 0, 32'(o_c[0]), 32'd0);

    // Fill credits=4 then drain back-to-back.
    o_r[0] = 1'b0;
    for (int k = 1; k <= 4; k++) beat(0, 8'(k));
    tick(2);
    chk("fill4_o_v", 0, 32'(o_v[0]), 32'd1);
    chk("fill4_head", 0, 32'(o_d[0]), 32'd1);
    o_r[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain4_o_d", 0, 32'(o_d[0]), 32'(k));
      tick();
      chk("drain4_o_c", 0, 32'(o_c[0]), 32'd1);
    end
    tick();
    chk("drain4_o_c_end", 0, 32'(o_c[0]), 32'd0);
    chk("drain4_o_err", 0, 32'(o_err[0]), 32'd0);

    // credits=3 overflow: beat dropped, sticky error, originals intact.
    o_r[1] = 1'b0;
    for (int k = 0; k < 3; k++) beat(1, 8'(8'h10 + k));
    beat(1, 8'h99);
    chk("ovf_o_err", 1, 32'(o_err[1]), 32'd1);
    o_r[1] = 1'b1;
    tick(5);
    chk("ovf_sticky", 1, 32'(o_err[1]), 32'd1);
    chk("ovf_empty", 1, 32'(o_v[1]), 32'd0);
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    chk("ovf_cleared", 1, 32'(o_err[1]), 32'd0);

    // Full with simultaneous enqueue and dequeue: no overflow, wraps pointers.
    o_r[1] = 1'b0;
    for (int k = 0; k < 3; k++) beat(1, 8'(8'h20 + k));
    o_r[1] = 1'b1;
    beat(1, 8'h09);
    chk("fulldeq_o_err", 1, 32'(o_err[1]), 32'd0);
    chk("fulldeq_o_d", 1, 32'(o_d[1]), 32'h21);
    tick(3);
    for (int k = 0; k < 4; k++) beat(1, 8'(8'h30 + k));
    tick(3);
    chk("wrap_o_err", 1, 32'(o_err[1]), 32'd0);

    // Mid-stream reset cancels the pending credit and flushes the buffer.
    o_r[0] = 1'b0;
    beat(0, 8'h40);
    beat(0, 8'h41);
    o_r[0] = 1'b1;
    tick();
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    chk("rst_o_v", 0, 32'(o_v[0]), 32'd0);
    chk("rst_o_c", 0, 32'(o_c[0]), 32'd0);
    beat(0, 8'h50);
    chk("post_rst_o_d", 0, 32'(o_d[0]), 32'h50);
    tick(3);

    o_r = 2'b00;
    tick(2);
    chk("conserve0", 0, 32'(gi[0].nc), 32'(gi[0].ndeq));
    chk("conserve1", 1, 32'(gi[1].nc), 32'(gi[1].ndeq));
    chk("sb_empty0", 0, 32'(gi[0].q.size()), 32'd0);
    chk("sb_empty1", 1, 32'(gi[1].q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
